reg_exec_master: RTL
====================

Name: reg_exec_master

Overview:
- Command-driven initiator for the 256x8 puzzle register file.
- Accepts one micro-op per valid/ready handshake and drives the file's read-address, write-address, write-enable and write-data ports.
- Samples the two combinational read outputs, computes the result, and writes it back.
- Sits between the puzzle-solver control sequencer and the register file. Provides the only write path into the file after reset.

Parameters:
AW, 8, register address width (256 entries)
DW, 8, register data width
OPW, 4, opcode width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  OPW  opcode
cmd_dst  in  AW  destination register
cmd_src0  in  AW  operand A register
cmd_src1  in  AW  operand B register
cmd_imm  in  DW  immediate / FILL count
rf_src0  out  AW  register file read address A
rf_src1  out  AW  register file read address B
rf_dst  out  AW  register file write address
rf_we  out  1  register file write enable
rf_data  out  DW  register file write data
rf_outa  in  DW  read data A (combinational from rf_src0)
rf_outb  in  DW  read data B (combinational from rf_src1)
done  out  1  one-cycle pulse: command retired
flag_z  out  1  last result == 0
flag_c  out  1  carry/borrow of last ADD/SUB/INC/DEC/SHL/SHR
err  out  1  one-cycle pulse with done: illegal opcode

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; cmd_ready=1.
  - rf_we=0; rf_src0/rf_src1/rf_dst/rf_data=0.
  - done=0, err=0, flag_z=0, flag_c=0.
  - Reset mid-command abandons it; no further writes occur.
- Opcodes:
  - 0 NOP
  - 1 MOV: dst=A
  - 2 LDI: dst=imm
  - 3 ADD: dst=A+B, c=carry-out
  - 4 SUB: dst=A-B, c=borrow (A<B)
  - 5 AND
  - 6 OR
  - 7 XOR
  - 8 INC: dst=A+1, c=(A==255)
  - 9 DEC: dst=A-1, c=(A==0)
  - 10 SHL: dst=A<<1, c=A[7]
  - 11 SHR: dst=A>>1, c=A[0]
  - 12 CMPEQ: dst=(A==B)
  - 13 CMPLT: unsigned, dst=(A<B)
  - 14 FILL: dst..dst+imm-1 = A
  - 15 illegal
- Width rule: all arithmetic is modulo 2^DW.
- Flags update only on ops that write. flag_c is held on logic ops, MOV, LDI, CMP and FILL.
- FSM: IDLE -> READ -> WB -> IDLE. FILL uses IDLE -> READ -> FILLW -> IDLE.
  - IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) at edge T latches all cmd_* fields. cmd_ready=0 from T.
  - READ (cycle T+1): rf_src0/rf_src1 = latched srcs. Operands A,B are captured at the end of the cycle. rf_we=0.
  - WB (cycle T+2): rf_dst=dst, rf_data=result, rf_we=1. done=1 in the same cycle. Next state IDLE, so cmd_ready=1 at T+3.
  - NOP/illegal: WB cycle with rf_we=0 and done=1. err=1 for illegal only.
- FILL:
  - 8-bit counter k starts at 0. FILLW asserts rf_we=1, rf_dst=dst+k (wraps modulo 256), rf_data=A, one entry per cycle.
  - done is asserted on the write where k==imm-1.
  - imm=0: a single FILLW cycle with rf_we=0 and done=1.
  - A is captured once in READ. If A's own register lies in the fill range, it is still written with the original value.
- Back-to-back: a command's write completes before the next command's READ, so read-after-write hazards are impossible.
- Outputs are registered. rf_src*/rf_dst/rf_data hold their last value while idle; only rf_we qualifies a write.

Decomposition:
- Package reg_exec_pkg holds:
  - opcode localparams OP_NOP..OP_FILL, OP_ILL
  - state encoding S_IDLE, S_READ, S_WB, S_FILLW
- One combinational sub-module, reg_exec_alu, maps (op, A, B, imm) to (result, carry).
- The FSM, latches and FILL counter stay in reg_exec_master.

Test Plan:
- Reset then LDI dst=0x10 imm=0xA5 -> rf_we=1, rf_dst=0x10, rf_data=0xA5 exactly 2 cycles after the handshake; done high the same cycle; cmd_ready low for 3 cycles.
- ADD A=0xF0 B=0x20 (model rf returns them) -> rf_data=0x10, flag_c=1, flag_z=0. Then SUB A=0x05 B=0x05 -> 0x00, flag_z=1, flag_c=0.
- FILL dst=0xFE imm=4 A=0x07 -> writes 0xFE, 0xFF, 0x00, 0x01 on 4 consecutive cycles; done only on the 4th. FILL imm=0 -> no rf_we, one done.
- Opcode 15 -> done=1, err=1, rf_we never asserted; flags unchanged.
- cmd_valid held high with 3 queued commands -> exactly one accepted per 3 cycles; a command reading the prior dst sees the new value.
- rst_n dropped during FILL (imm=10) at the 3rd write -> rf_we=0 immediately (async), cmd_ready=1, no further writes after release.

Source files
------------

// File: rtl/reg_exec_pkg.sv
// rtl/reg_exec_pkg.sv - opcodes, FSM state encoding and opcode classifiers for reg_exec_master
package reg_exec_pkg;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_MOV   = 4'd1;
   localparam logic [3:0] OP_LDI   = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_AND   = 4'd5;
   localparam logic [3:0] OP_OR    = 4'd6;
   localparam logic [3:0] OP_XOR   = 4'd7;
   localparam logic [3:0] OP_INC   = 4'd8;
   localparam logic [3:0] OP_DEC   = 4'd9;
   localparam logic [3:0] OP_SHL   = 4'd10;
   localparam logic [3:0] OP_SHR   = 4'd11;
   localparam logic [3:0] OP_CMPEQ = 4'd12;
   localparam logic [3:0] OP_CMPLT = 4'd13;
   localparam logic [3:0] OP_FILL  = 4'd14;
   localparam logic [3:0] OP_ILL   = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WB    = 2'd2,
      S_FILLW = 2'd3
   } state_t;

   // single-write ops; FILL is sequenced separately by the master
   function automatic logic op_writes(input logic [3:0] op);
      return (op >= OP_MOV) && (op <= OP_CMPLT);
   endfunction

   function automatic logic op_sets_c(input logic [3:0] op);
      return op inside {OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_SHL, OP_SHR};
   endfunction

endpackage

// File: rtl/reg_exec_master_if.sv
// rtl/reg_exec_master_if.sv - command and register-file bus between sequencer, reg_exec_master and the file
interface reg_exec_master_if #(
   parameter int AW  = 8,
   parameter int DW  = 8,
   parameter int OPW = 4
);
   logic           cmd_valid;
   logic           cmd_ready;
   logic [OPW-1:0] cmd_op;
   logic [AW-1:0]  cmd_dst;
   logic [AW-1:0]  cmd_src0;
   logic [AW-1:0]  cmd_src1;
   logic [DW-1:0]  cmd_imm;
   logic [AW-1:0]  rf_src0;
   logic [AW-1:0]  rf_src1;
   logic [AW-1:0]  rf_dst;
   logic           rf_we;
   logic [DW-1:0]  rf_data;
   logic [DW-1:0]  rf_outa;
   logic [DW-1:0]  rf_outb;
   logic           done;
   logic           flag_z;
   logic           flag_c;
   logic           err;

   modport master (
      input  cmd_valid, cmd_op, cmd_dst, cmd_src0, cmd_src1, cmd_imm, rf_outa, rf_outb,
      output cmd_ready, rf_src0, rf_src1, rf_dst, rf_we, rf_data, done, flag_z, flag_c, err
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_dst, cmd_src0, cmd_src1, cmd_imm, rf_outa, rf_outb,
      input  cmd_ready, rf_src0, rf_src1, rf_dst, rf_we, rf_data, done, flag_z, flag_c, err
   );
endinterface

// File: rtl/reg_exec_alu.sv
// rtl/reg_exec_alu.sv - combinational result/carry for one micro-op
module reg_exec_alu
   import reg_exec_pkg::*;
#(
   parameter int DW  = 8,
   parameter int OPW = 4
) (
   input  logic [OPW-1:0] op,
   input  logic [DW-1:0]  a,
   input  logic [DW-1:0]  b,
   input  logic [DW-1:0]  imm,
   output logic [DW-1:0]  result,
   output logic           carry
);
   logic [DW:0] sum;

   assign sum = {1'b0, a} + {1'b0, b};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_MOV:   result = a;
         OP_LDI:   result = imm;
         OP_ADD:   begin result = sum[DW-1:0]; carry = sum[DW]; end
         OP_SUB:   begin result = a - b; carry = (a < b); end
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_XOR:   result = a ^ b;
         OP_INC:   begin result = a + 1'b1; carry = (a == {DW{1'b1}}); end
         OP_DEC:   begin result = a - 1'b1; carry = (a == '0); end
         OP_SHL:   begin result = {a[DW-2:0], 1'b0}; carry = a[DW-1]; end
         OP_SHR:   begin result = {1'b0, a[DW-1:1]}; carry = a[0]; end
         OP_CMPEQ: result = {{(DW-1){1'b0}}, (a == b)};
         OP_CMPLT: result = {{(DW-1){1'b0}}, (a < b)};
         OP_FILL:  result = a;
         default:  result = '0;
      endcase
   end
endmodule

// File: rtl/reg_exec_master.sv
// rtl/reg_exec_master.sv - micro-op initiator: latch command, read operands, write result back to the register file
module reg_exec_master
   import reg_exec_pkg::*;
#(
   parameter int AW  = 8,
   parameter int DW  = 8,
   parameter int OPW = 4
) (
   input  logic clk,
   input  logic rst_n,
   reg_exec_master_if.master bus
);
   state_t         state_q, state_d;
   logic [OPW-1:0] op_q, op_d;
   logic [AW-1:0]  dst_q, dst_d;
   logic [DW-1:0]  imm_q, imm_d;
   logic [DW-1:0]  a_q, a_d;
   logic [DW-1:0]  k_q, k_d;
   logic [AW-1:0]  src0_q, src0_d, src1_q, src1_d, rfdst_q, rfdst_d;
   logic [DW-1:0]  data_q, data_d;
   logic           ready_q, ready_d, we_q, we_d, done_q, done_d, err_q, err_d;
   logic           z_q, z_d, c_q, c_d;
   logic [DW-1:0]  alu_result;
   logic           alu_carry;
   logic           handshake, fill_last;

   reg_exec_alu #(.DW(DW), .OPW(OPW)) u_alu (
      .op     (op_q),
      .a      (bus.rf_outa),
      .b      (bus.rf_outb),
      .imm    (imm_q),
      .result (alu_result),
      .carry  (alu_carry)
   );

   assign handshake = bus.cmd_valid & ready_q;
   assign fill_last = (imm_q == '0) || (k_q == imm_q - 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (handshake) state_d = S_READ;
         S_READ:  state_d = (op_q == OP_FILL) ? S_FILLW : S_WB;
         S_WB:    state_d = S_IDLE;
         S_FILLW: if (fill_last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Computes the next value of every registered output; pulses default low.
   always_comb begin
      op_d    = op_q;
      dst_d   = dst_q;
      imm_d   = imm_q;
      a_d     = a_q;
      k_d     = k_q;
      src0_d  = src0_q;
      src1_d  = src1_q;
      rfdst_d = rfdst_q;
      data_d  = data_q;
      ready_d = ready_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      z_d     = z_q;
      c_d     = c_q;
      case (state_q)
         S_IDLE: begin
            if (handshake) begin
               op_d    = bus.cmd_op;
               dst_d   = bus.cmd_dst;
               imm_d   = bus.cmd_imm;
               src0_d  = bus.cmd_src0;
               src1_d  = bus.cmd_src1;
               ready_d = 1'b0;
            end
         end
         S_READ: begin
            a_d = bus.rf_outa;
            k_d = '0;
            if (op_q == OP_FILL) begin
               rfdst_d = dst_q;
               data_d  = alu_result;
               we_d    = (imm_q != '0);
               done_d  = (imm_q <= 1);
               if (imm_q != '0) z_d = (alu_result == '0);
            end else begin
               done_d = 1'b1;
               err_d  = (op_q == OP_ILL);
               if (op_writes(op_q)) begin
                  rfdst_d = dst_q;
                  data_d  = alu_result;
                  we_d    = 1'b1;
                  z_d     = (alu_result == '0);
                  if (op_sets_c(op_q)) c_d = alu_carry;
               end
            end
         end
         S_WB: ready_d = 1'b1;
         S_FILLW: begin
            if (fill_last) begin
               ready_d = 1'b1;
            end else begin
               k_d     = k_q + 1'b1;
               rfdst_d = dst_q + AW'(k_q) + 1'b1;
               we_d    = 1'b1;
               done_d  = ((k_q + 1'b1) == (imm_q - 1'b1));
            end
         end
         default: ready_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= '0;
         dst_q   <= '0;
         imm_q   <= '0;
         a_q     <= '0;
         k_q     <= '0;
         src0_q  <= '0;
         src1_q  <= '0;
         rfdst_q <= '0;
         data_q  <= '0;
         ready_q <= 1'b1;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         op_q    <= op_d;
         dst_q   <= dst_d;
         imm_q   <= imm_d;
         a_q     <= a_d;
         k_q     <= k_d;
         src0_q  <= src0_d;
         src1_q  <= src1_d;
         rfdst_q <= rfdst_d;
         data_q  <= (state_q == S_FILLW) ? a_q : data_d;
         ready_q <= ready_d;
         we_q    <= we_d;
         done_q  <= done_d;
         err_q   <= err_d;
         z_q     <= z_d;
         c_q     <= c_d;
      end
   end

   assign bus.cmd_ready = ready_q;
   assign bus.rf_src0   = src0_q;
   assign bus.rf_src1   = src1_q;
   assign bus.rf_dst    = rfdst_q;
   assign bus.rf_we     = we_q;
   assign bus.rf_data   = data_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.flag_z    = z_q;
   assign bus.flag_c    = c_q;
endmodule
